// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the MAC RX AXI-Stream: each frame is forwarded or
// discarded based on its first beat. Accepted beats leave through a two-entry skid stage.
module eth_rx_mac_filter #(
  parameter int DW    = 64,
  parameter int KW    = DW/8,
  parameter int UW    = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    s_axis_tdata_i,
  input  logic [KW-1:0]    s_axis_tkeep_i,
  input  logic             s_axis_tlast_i,
  input  logic [UW-1:0]    s_axis_tuser_i,
  input  logic             s_axis_tvalid_i,
  output logic             s_axis_tready_o,
  output logic [DW-1:0]    m_axis_tdata_o,
  output logic [KW-1:0]    m_axis_tkeep_o,
  output logic             m_axis_tlast_o,
  output logic [UW-1:0]    m_axis_tuser_o,
  output logic             m_axis_tvalid_o,
  input  logic             m_axis_tready_i,
  input  logic [47:0]      mac_addr_i,
  input  logic             promisc_i,
  input  logic             bcast_en_i,
  input  logic             mcast_en_i,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int BW = DW + KW + 1 + UW;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t        state;
  logic          rdy_q;
  logic          skid_vld;
  logic          skid_nxt;
  logic          out_free;
  logic          acc;
  logic          fwd;
  logic          pass_end;
  logic          drop_end;
  logic          runt_p0, uc_p0, bc_p0, mc_p0, pass_p0;
  logic [47:0]   da_p0;
  logic [BW-1:0] in_beat;
  logic [BW-1:0] skid_beat;
  logic [BW-1:0] out_beat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + ONE;
  endfunction

  // Stage p0: first-beat classification, combinational on the input beat
  assign da_p0   = s_axis_tdata_i[47:0];
  assign runt_p0 = (s_axis_tkeep_i[5:0] != 6'h3F);
  assign uc_p0   = (da_p0 == mac_addr_i);
  assign bc_p0   = (da_p0 == 48'hFFFF_FFFF_FFFF);
  assign mc_p0   = (da_p0[47:24] == 24'h01005E);
  assign pass_p0 = !runt_p0 && (promisc_i || uc_p0 || (bc_p0 && bcast_en_i) || (mc_p0 && mcast_en_i));

  // DROP sinks unconditionally; otherwise ready mirrors the registered skid-empty flag
  assign s_axis_tready_o = rdy_q || (state == DROP);
  assign acc      = s_axis_tvalid_i && s_axis_tready_o;
  assign fwd      = acc && (((state == IDLE) && pass_p0) || (state == PASS));
  assign pass_end = fwd && s_axis_tlast_i;
  assign drop_end = acc && s_axis_tlast_i && (((state == IDLE) && !pass_p0) || (state == DROP));

  assign in_beat  = {s_axis_tuser_i, s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i};
  assign out_free = !m_axis_tvalid_o || m_axis_tready_i;
  assign skid_nxt = out_free ? 1'b0 : (skid_vld || fwd);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else if (acc) begin
      case (state)
        IDLE:    if (!s_axis_tlast_i) state <= pass_p0 ? PASS : DROP;
        PASS,
        DROP:    if (s_axis_tlast_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: output register (skid entry 0) plus overflow entry 1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_beat        <= '0;
      m_axis_tvalid_o <= 1'b0;
      skid_vld        <= 1'b0;
      rdy_q           <= 1'b0;
    end else begin
      skid_vld <= skid_nxt;
      rdy_q    <= !skid_nxt;
      if (out_free) begin
        if (skid_vld) begin
          out_beat        <= skid_beat;
          m_axis_tvalid_o <= 1'b1;
        end else if (fwd) begin
          out_beat        <= in_beat;
          m_axis_tvalid_o <= 1'b1;
        end else begin
          m_axis_tvalid_o <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!out_free && fwd) skid_beat <= in_beat;
  end

  assign m_axis_tdata_o = out_beat[DW-1:0];
  assign m_axis_tkeep_o = out_beat[DW +: KW];
  assign m_axis_tlast_o = out_beat[DW+KW];
  assign m_axis_tuser_o = out_beat[DW+KW+1 +: UW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (pass_end) pass_cnt_o <= sat_inc(pass_cnt_o);
      if (drop_end) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

endmodule
